// File: rtl/cell_pos_reader.sv
// cell_pos_reader: fetches a cell's particle count, then streams
// particle words from a 2-cycle-latency memory through valid/ready.
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_ovf,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PMAX = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_rden_q, mem_rden_d;
  logic [ADDR_WIDTH-1:0]   pcount_q, pcount_d;
  logic                    ovf_q, ovf_d;
  logic                    wait_q, wait_d;
  logic                    v1_q, v1_d, v2_q, v2_d;
  logic [ADDR_WIDTH-1:0]   a1_q, a1_d, a2_q, a2_d;
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   idx_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   idx_d  [FIFO_DEPTH];

  logic                    push, pop, credit, drained;
  logic [CW:0]             used, limit;
  logic [ADDR_WIDTH-1:0]   cnt_raw, cnt_clamp;
  logic                    cnt_big;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (cnt_q != '0);
  assign push      = v2_q;
  assign pop       = out_valid & out_ready;

  // A pop this cycle returns its credit to the next issue decision.
  assign used  = (CW+1)'(cnt_q) + (CW+1)'(mem_rden_q)
               + (CW+1)'(v1_q) + (CW+1)'(v2_q);
  assign limit = DEPTH_C + (CW+1)'(pop);
  assign credit = (used < limit);

  assign drained = !mem_rden_q && !v1_q && !v2_q &&
                   ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop));

  assign cnt_raw   = mem_q[ADDR_WIDTH-1:0];
  assign cnt_big   = (cnt_raw > PMAX);
  assign cnt_clamp = cnt_big ? PMAX : cnt_raw;

  // Next state and memory-port request.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rden_d = 1'b0;
    pcount_d   = pcount_q;
    ovf_d      = ovf_q;
    wait_d     = wait_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CNT_REQ;
          mem_addr_d = '0;
          mem_rden_d = 1'b1;
          ovf_d      = 1'b0;
          wait_d     = 1'b0;
        end
      end
      CNT_REQ: state_d = CNT_WAIT;
      CNT_WAIT: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          pcount_d = cnt_clamp;
          ovf_d    = cnt_big;
          if (cnt_clamp == '0) begin
            state_d = DONE;
          end else begin
            state_d    = STREAM;
            mem_addr_d = ADDR_WIDTH'(1);
            mem_rden_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (mem_addr_q == pcount_q) begin
          state_d = DRAIN;
        end else if (credit) begin
          mem_addr_d = mem_addr_q + 1'b1;
          mem_rden_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drained) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In-flight tracking and the output FIFO.
  always_comb begin
    v1_d   = mem_rden_q && (mem_addr_q != '0);
    a1_d   = mem_addr_q;
    v2_d   = v1_q;
    a2_d   = a1_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    idx_d  = idx_q;
    if (push) begin
      data_d[wr_q] = mem_q;
      idx_d[wr_q]  = a2_q;
      wr_d         = nxt(wr_q);
    end
    if (pop) rd_d = nxt(rd_q);
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      mem_rden_q <= 1'b0;
      pcount_q   <= '0;
      ovf_q      <= 1'b0;
      wait_q     <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      a1_q       <= '0;
      a2_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rden_q <= mem_rden_d;
      pcount_q   <= pcount_d;
      ovf_q      <= ovf_d;
      wait_q     <= wait_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign count_ovf      = ovf_q;
  assign particle_count = pcount_q;
  assign mem_addr       = mem_addr_q;
  assign mem_rden       = mem_rden_q;
  assign mem_wren       = 1'b0;
  assign out_data       = data_q[rd_q];
  assign out_index      = idx_q[rd_q];
  assign out_last       = out_valid && (idx_q[rd_q] == pcount_q);

endmodule

// File: tb/tb_cell_pos_reader.sv
// tb_cell_pos_reader: scoreboard bench with a 2-cycle memory model
// and a word-list reference of each cell's expected stream.
module tb_cell_pos_reader;
  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_n, start, out_ready;
  logic busy, done, count_ovf, mem_rden, mem_wren;
  logic out_valid, out_last;
  logic [AW-1:0] particle_count, mem_addr, out_index;
  logic [DW-1:0] mem_q, out_data;

  cell_pos_reader #(
    .DATA_WIDTH(DW), .PARTICLE_NUM(PN),
    .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .count_ovf(count_ovf),
    .particle_count(particle_count),
    .mem_addr(mem_addr), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_q(mem_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .out_last(out_last)
  );

  initial forever #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] p1;

  always @(posedge clk) begin
    p1    <= mem_rden ? mem[mem_addr] : {3{32'hDEADBEEF}};
    mem_q <= p1;
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] i;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  exp_t em;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_start = -100;
  int exp_done = 0;
  int done_cnt = 0;
  int xfers = 0;
  int reads = 0;
  int outst = 0;
  int last_xfer = 0;
  int nc_cur = 0;
  int rmode = 0;
  bit nostall = 1'b1;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [DW-1:0] pd;
  logic [AW-1:0] pi;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = !(cyc >= t_start + 7 && cyc <= t_start + 15);
        default: out_ready = ($urandom_range(2) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_index", out_index, pi);
      end
      if (mem_rden && mem_addr != 0) begin
        reads++;
        outst++;
        chk("credit", outst <= FD, 1);
        if (nostall) chk("issue_cyc", cyc, t_start + 3 + int'(mem_addr));
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL xfer_unexpected: got index %0d want none",
                   out_index);
        end else begin
          em = exp_q.pop_front();
          chk("xfer_data", out_data, em.d);
          chk("xfer_index", out_index, em.i);
          chk("xfer_last", out_last, em.l);
          if (nostall) chk("xfer_cyc", cyc, t_start + 6 + int'(em.i));
        end
        xfers++;
        outst--;
        last_xfer = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 1);
        if (nostall) chk("done_cyc", cyc, exp_done);
        if (nc_cur > 0) chk("done_after_last", cyc, last_xfer + 1);
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pi = out_index;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", count_ovf, 0);
    chk("rst_rden", mem_rden, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pcount", particle_count, 0);
    chk("rst_index", out_index, 0);
    chk("rst_data", out_data, 0);
  endtask

  task automatic begin_cell(input int n_raw, input int mode);
    int nc;
    exp_t t;
    nc = (n_raw > PN - 1) ? PN - 1 : n_raw;
    mem[0] = {$urandom(), $urandom(), 32'(n_raw)};
    for (int k = 1; k < PN; k++)
      mem[k] = {$urandom(), $urandom(), $urandom()};
    for (int k = 1; k <= nc; k++) begin
      t.d = mem[k];
      t.i = AW'(k);
      t.l = (k == nc);
      exp_q.push_back(t);
    end
    rmode   = mode;
    nostall = (mode == 0);
    nc_cur  = nc;
    reads   = 0;
    outst   = 0;
    @(posedge clk);
    #1;
    start    = 1'b1;
    t_start  = cyc;
    exp_done = (nc == 0) ? t_start + 4 : t_start + 7 + nc;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_t1", busy, 1);
    chk("ovf_cleared", count_ovf, 0);
    chk("cnt_req_rden", mem_rden, 1);
    chk("cnt_req_addr", mem_addr, 0);
  endtask

  task automatic run_cell(input int n_raw, input int mode,
                          input bit glitch);
    int nc;
    int d0;
    nc = (n_raw > PN - 1) ? PN - 1 : n_raw;
    d0 = done_cnt;
    begin_cell(n_raw, mode);
    if (glitch) begin
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("one_done", done_cnt - d0, 1);
    chk("busy_idle", busy, 0);
    chk("pcount", particle_count, nc);
    chk("ovf", count_ovf, n_raw > PN - 1);
    chk("reads", reads, nc);
    chk("drained", exp_q.size(), 0);
    chk("wren", mem_wren, 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_run();
    int x0;
    x0 = xfers;
    begin_cell(5, 0);
    for (int i = 0; i < 200 && xfers < x0 + 3; i++) begin
      @(negedge clk);
      #1;
    end
    if (xfers < x0 + 3) chk("third_xfer_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_cell(5, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_cell(5, 0, 1'b0);
    run_cell(0, 0, 1'b0);
    run_cell(5, 1, 1'b0);
    run_cell(250, 0, 1'b0);
    run_cell(3, 0, 1'b0);
    reset_mid_run();
    run_cell(8, 0, 1'b1);
    run_cell(1, 0, 1'b0);
    for (int r = 0; r < 6; r++)
      run_cell(int'($urandom_range(255)), (r % 2) * 2, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cell_pos_reader.md
# cell_pos_reader

Read-side initiator for one single-port cell position memory: word 0 holds the cell's particle count, words 1..N hold {posz, posy, posx}. On `start` it fetches the count, then streams every particle word out through a valid/ready interface. It absorbs the memory's fixed 2-cycle read latency and downstream backpressure. It sits between a cell memory and the force-evaluation / motion-update pipelines, and it owns the memory port while `busy`.

## Interface
- DATA_WIDTH, 96: memory word width, {posz, posy, posx}, 32 bits each.
- PARTICLE_NUM, 220: memory depth in words, including the count word.
- ADDR_WIDTH, 8: memory address width.
- FIFO_DEPTH, 4: output buffer depth. Must be at least 3 to cover the read latency.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a cell read. Sampled only in IDLE.
- busy  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- done  out  1  one-cycle pulse when the stream is complete.
- count_ovf  out  1  sticky flag: the count word exceeded PARTICLE_NUM-1. Cleared by the next accepted `start`.
- particle_count  out  ADDR_WIDTH  count after clamping. Valid from the cycle after capture until the next `start`.
- mem_addr  out  ADDR_WIDTH  memory address (registered).
- mem_rden  out  1  memory read enable (registered).
- mem_wren  out  1  memory write enable; constant 0.
- mem_q  in  DATA_WIDTH  memory read data. Valid exactly 2 cycles after the cycle in which `mem_rden`=1 is presented.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  downstream accepts data. A transfer occurs on a cycle where `out_valid` and `out_ready` are both high.
- out_data  out  DATA_WIDTH  particle word.
- out_index  out  ADDR_WIDTH  address of the particle word, 1..N.
- out_last  out  1  qualifies the final particle (`out_index` == N).

## Operation
- FSM states are IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE.
- IDLE → CNT_REQ when `start`=1.
- CNT_REQ: `mem_addr`=0 and `mem_rden`=1 for one cycle, then go to CNT_WAIT.
- CNT_WAIT: wait 2 cycles. On the second cycle capture N = `mem_q[ADDR_WIDTH-1:0]`.
  - If N > PARTICLE_NUM-1, clamp N to PARTICLE_NUM-1 and set `count_ovf`.
  - If N == 0, go to DONE; otherwise go to STREAM.
- STREAM issues one read per cycle at addresses 1, 2, … N, under a credit rule: issue only when (FIFO occupancy + reads in flight) < FIFO_DEPTH.
  - Reads in flight are tracked by a 2-stage valid shift register.
  - Each returning `mem_q` is pushed into the FIFO together with its address.
  - After address N is issued, go to DRAIN.
- DRAIN: wait until no reads are in flight and the FIFO is empty (the last pop has occurred), then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `mem_rden` is 0 in every cycle where no read is issued; `mem_addr` holds its last value.
- The FIFO never overflows, by construction of the credit rule. A push and a pop in the same cycle leave occupancy unchanged.
- `start` is ignored outside IDLE.
- Reset mid-operation: everything returns to reset values immediately. The FIFO and in-flight tracking are cleared, and late `mem_q` returns are discarded.
- Reset values:
  - `busy`, `done`, `count_ovf`, `mem_rden`, `mem_wren`, `out_valid`, `out_last` are 0.
  - `mem_addr`, `particle_count`, `out_index`, `out_data` are 0.
  - FSM is in IDLE.

## Timing
- `start` is sampled high in IDLE at cycle T.
- T+1: `mem_addr`=0, `mem_rden`=1, `busy`=1.
- T+3: count word on `mem_q`, captured at the end of T+3. `particle_count` is valid from T+4.
- With `out_ready` held 1:
  - The read of address k is issued at T+3+k.
  - Its data is at `mem_q` at T+5+k.
  - It is presented on `out_*` at T+6+k, because the FIFO output is registered.
  - Throughput is 1 word per cycle.
- Last transfer is at T+6+N; `done` pulses at T+7+N; `busy` falls at T+8+N.
- N == 0: `done` pulses at T+4 with no `out_valid`.
- Under backpressure, `out_data`, `out_index` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- Issue resumes the cycle after a pop frees a credit.

## Test plan
- Count 5, particles 1..5, `out_ready`=1, `start` at T:
  - reads issued to addresses 1..5 at T+4..T+8;
  - `out_valid` T+7..T+11 with `out_index` 1..5;
  - `out_last` only at T+11; `done` at T+12.
- Count 0: no `mem_rden` after address 0; `done` at T+4; `out_valid` never asserted.
- Count 5, `out_ready`=0 from T+7 to T+15, then 1:
  - at most FIFO_DEPTH reads are outstanding; no word is lost or duplicated;
  - `out_data` is held stable while stalled;
  - indices 1..5 arrive in order; `done` follows the last transfer by 1 cycle.
- Count word 250 with PARTICLE_NUM 220: `particle_count`=219, `count_ovf`=1, exactly 219 transfers; `count_ovf` clears on the next `start`.
- `rst_n` asserted at the third transfer of a count-5 run: all outputs reach reset values immediately. After release, a new `start` produces a clean 1..5 stream with no stale data.
- `start` pulsed during STREAM: ignored; count and stream unaffected; one `done` only.
